uart_tx_arbiter: RTL and testbench

Shared UART transmitter with a two-requester round-robin arbiter. It sits between two byte producers and the single `tx` pin. The baud-rate generator's `max_tick` output drives it as a 16× oversampling tick. It grants one requester at a time, serialises the granted byte as a standard 8N1-style frame, and alternates fairly between requesters under contention.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shared UART transmitter fed by two byte producers through a round-robin arbiter.
// Frames are start bit, DBIT data bits LSB first, then SB_TICK ticks of stop.
module uart_tx_arbiter #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            req0,
    input  logic [DBIT-1:0] data0,
    input  logic            req1,
    input  logic [DBIT-1:0] data1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            owner,
    output logic            busy,
    output logic            tx_done_tick,
    output logic            tx
);
    localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_reg_q, b_reg_d;
    logic [DBIT-1:0] b_shift;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done_q, done_d;
    logic            tx_q, tx_d;
    logic            pick;

    assign b_shift = b_reg_q >> 1;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_reg_d = b_reg_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done_d  = 1'b0;
        tx_d    = tx_q;
        pick    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (req0 || req1) begin
                    // Under contention the requester not served last wins.
                    pick    = (req0 && req1) ? ~last_q : req1;
                    b_reg_d = pick ? data1 : data0;
                    owner_d = pick;
                    last_d  = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    s_cnt_d = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        tx_d    = b_reg_q[0];
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        b_reg_d = b_shift;
                        if (n_cnt_q == N_LAST) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                            tx_d    = b_shift[0];
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        s_cnt_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_reg_q <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_reg_q <= b_reg_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign owner        = owner_q;
    assign busy         = (state_q != IDLE);
    assign tx_done_tick = done_q;
    assign tx           = tx_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single frame timing, contention,
// tick gating, withdrawn request and mid-frame reset.
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_tick = 1'b1;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, owner, busy, tx_done_tick, tx;

    int total = 0;
    int bad = 0;
    int tick_per = 1;
    int tcnt = 0;
    int gnt1_cnt = 0;

    uart_tx_arbiter #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tick       (s_tick),
        .req0         (req0),
        .data0        (data0),
        .req1         (req1),
        .data1        (data1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .owner        (owner),
        .busy         (busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_per <= 1) begin
            s_tick = 1'b1;
        end else begin
            tcnt   = (tcnt + 1) % tick_per;
            s_tick = (tcnt == 0);
        end
    end

    always @(negedge clk) if (gnt1 === 1'b1) gnt1_cnt++;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (tx_done_tick !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for a grant, then samples tx at bit centres (bitlen clk cycles per bit).
    task automatic rx_frame(input int bitlen, input bit drop, output logic [7:0] b,
                            output int who, output logic stop_bit, output logic own);
        int n;
        who = -1;
        b = '0;
        stop_bit = 1'b0;
        own = 1'b0;
        n = 0;
        while (!(gnt0 === 1'b1 || gnt1 === 1'b1) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
            who = (gnt1 === 1'b1) ? 1 : 0;
            own = owner;
            if (drop) begin
                if (gnt0 === 1'b1) req0 = 1'b0;
                if (gnt1 === 1'b1) req1 = 1'b0;
            end
            repeat (bitlen / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (bitlen) @(negedge clk);
                b[i] = tx;
            end
            repeat (bitlen) @(negedge clk);
            stop_bit = tx;
            wait_done(4 * bitlen, n);
        end
    endtask

    initial begin
        int         n, who, t1, t2, t3, td, donecnt, g0;
        logic [7:0] b, d;
        logic       sb, own, prev, eb;
        logic [15:0] seg [10];

        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        data0 = '0;
        data1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_eq("rst_tx", 32'(tx), 32'd1);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk_eq("rst_owner", 32'(owner), 32'd0);
        chk_eq("rst_done", 32'(tx_done_tick), 32'd0);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        chk_eq("idle_quiet", 32'(n), 32'd0);

        // Single frame A5, tick tied high
        d = 8'hA5;
        data0 = d;
        req0 = 1'b1;
        @(negedge clk);
        chk_eq("a5_gnt0", 32'(gnt0), 32'd1);
        chk_eq("a5_gnt1", 32'(gnt1), 32'd0);
        chk_eq("a5_tx_start", 32'(tx), 32'd0);
        chk_eq("a5_busy", 32'(busy), 32'd1);
        chk_eq("a5_owner", 32'(owner), 32'd0);
        req0 = 1'b0;
        donecnt = 0;
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge clk);
            seg[k / 16][k % 16] = tx;
            if (tx_done_tick === 1'b1) donecnt++;
            if (k == 1) chk_eq("a5_gnt0_pulse", 32'(gnt0), 32'd0);
        end
        for (int j = 0; j < 10; j++) begin
            if (j == 0) eb = 1'b0;
            else if (j == 9) eb = 1'b1;
            else eb = d[j - 1];
            chk_eq($sformatf("a5_seg%0d", j), 32'(seg[j]), 32'({16{eb}}));
        end
        chk_eq("a5_no_early_done", 32'(donecnt), 32'd0);
        @(negedge clk);
        chk_eq("a5_done_at_160", 32'(tx_done_tick), 32'd1);
        chk_eq("a5_busy_fall", 32'(busy), 32'd0);
        chk_eq("a5_tx_idle", 32'(tx), 32'd1);
        @(negedge clk);
        chk_eq("a5_done_pulse", 32'(tx_done_tick), 32'd0);

        // Contention from reset: 11, 22, 11, 22
        rst_n = 1'b0;
        @(negedge clk);
        data0 = 8'h11;
        data1 = 8'h22;
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 4; f++) begin
            rx_frame(16, 1'b0, b, who, sb, own);
            chk_eq($sformatf("rr%0d_who", f), 32'(who), 32'(f % 2));
            chk_eq($sformatf("rr%0d_owner", f), 32'(own), 32'(f % 2));
            chk_eq($sformatf("rr%0d_byte", f), 32'(b), (f % 2 == 1) ? 32'h22 : 32'h11);
            chk_eq($sformatf("rr%0d_stop", f), 32'(sb), 32'd1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        chk_eq("rr_idle_after", 32'(busy), 32'd0);

        // Tick every 10 cycles, byte 0F: four 1-bits then four 0-bits
        tick_per = 10;
        data1 = 8'h0F;
        req1 = 1'b1;
        @(negedge clk);
        chk_eq("tk_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        t1 = -1; t2 = -1; t3 = -1; td = -1;
        prev = tx;
        for (int k = 1; k < 2500 && td < 0; k++) begin
            @(negedge clk);
            if (tx !== prev) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
                else if (t3 < 0) t3 = k;
            end
            prev = tx;
            if (tx_done_tick === 1'b1) td = k;
        end
        chk_eq("tk_start_len", 32'(t1 >= 151 && t1 <= 160), 32'd1);
        chk_eq("tk_ones_len", 32'(t2 - t1), 32'd640);
        chk_eq("tk_zeros_len", 32'(t3 - t2), 32'd640);
        chk_eq("tk_stop_len", 32'(td - t3), 32'd160);
        tick_per = 1;
        repeat (3) @(negedge clk);

        // Withdrawn req1 pulse during a frame
        g0 = gnt1_cnt;
        data0 = 8'h55;
        req0 = 1'b1;
        @(negedge clk);
        chk_eq("wd_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        repeat (20) @(negedge clk);
        chk_eq("wd_busy", 32'(busy), 32'd1);
        data1 = 8'h99;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        wait_done(400, n);
        chk_eq("wd_done", 32'(tx_done_tick), 32'd1);
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) n++;
        end
        chk_eq("wd_no_frame", 32'(n), 32'd0);
        chk_eq("wd_no_gnt1", 32'(gnt1_cnt - g0), 32'd0);

        // Reset during data bit 3 of an F7 frame from requester 1
        data1 = 8'hF7;
        req1 = 1'b1;
        @(negedge clk);
        chk_eq("rm_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        repeat (70) @(negedge clk);
        chk_eq("rm_pre_tx", 32'(tx), 32'd0);
        chk_eq("rm_pre_owner", 32'(owner), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("rm_tx_async", 32'(tx), 32'd1);
        chk_eq("rm_busy", 32'(busy), 32'd0);
        chk_eq("rm_owner", 32'(owner), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        data0 = 8'h3C;
        req0 = 1'b1;
        rx_frame(16, 1'b1, b, who, sb, own);
        chk_eq("rm_who", 32'(who), 32'd0);
        chk_eq("rm_byte", 32'(b), 32'h3C);
        chk_eq("rm_stop", 32'(sb), 32'd1);
        chk_eq("rm_done", 32'(tx_done_tick), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
